// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier sequencers: state encoding
// and the default result word width.
package mm_pkg;

    localparam int MM_DATA_W = 32;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_PUSH = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_RD   = S_RD,
        ST_WAIT = S_WAIT,
        ST_PUSH = S_PUSH,
        ST_DONE = S_DONE
    } drain_state_t;

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) walker over an N x N matrix; wraps to (0,0) after the
// final element.
module matrix_index_counter
    import mm_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);

    assign last = (row == MAX_IDX) && (col == MAX_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == MAX_IDX) begin
                col <= '0;
                row <= (row == MAX_IDX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_drain_ctrl.sv
// Drains an N x N result matrix from the multiplier's result RAM onto a
// valid/ready stream in row-major order, one read per element.
module result_drain_ctrl
    import mm_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = MM_DATA_W,
    parameter int IDX_W  = $clog2(N),
    parameter int ADDR_W = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_col,
    output logic              out_last
);

    localparam bit N_POW2 = ((N & (N - 1)) == 0);

    drain_state_t     state;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             idx_last;
    logic             clr;
    logic             inc;

    // Power-of-two N turns row*N into a plain shift.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] r,
                                                  input logic [IDX_W-1:0] c);
        if (N_POW2)
            return (ADDR_W'(r) << IDX_W) | ADDR_W'(c);
        else
            return ADDR_W'(r) * ADDR_W'(N) + ADDR_W'(c);
    endfunction

    // The counter advances as the word is captured, so during PUSH it already
    // points at the next element and the address is ready for the next RD.
    assign clr = (state == ST_IDLE) && start;
    assign inc = (state == ST_WAIT);

    matrix_index_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (inc),
        .row  (row),
        .col  (col),
        .last (idx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else begin
            mem_addr <= (state == ST_IDLE) ? '0 : addr_of(row, col);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RD;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                    end
                end
                ST_RD: begin
                    state     <= ST_WAIT;
                    mem_rd_en <= 1'b0;
                end
                // Read data lands here; capture it with its coordinates.
                ST_WAIT: begin
                    state     <= ST_PUSH;
                    out_valid <= 1'b1;
                    out_data  <= mem_rd_data;
                    out_row   <= row;
                    out_col   <= col;
                    out_last  <= idx_last;
                end
                ST_PUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_RD;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Directed bench for result_drain_ctrl: an N=2 instance for cycle-exact checks
// and an N=8 instance for a throttled full drain.
module tb_result_drain_ctrl;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
    } hs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // N = 2 instance
    logic        start_a = 1'b0, ready_a = 1'b1;
    logic        busy_a, done_a, rd_en_a, valid_a, last_a;
    logic [1:0]  addr_a;
    logic [31:0] rdata_a, data_a;
    logic [0:0]  row_a, col_a;
    logic [31:0] mem_a [4];

    // N = 8 instance
    logic        start_b = 1'b0, ready_b = 1'b1;
    logic        busy_b, done_b, rd_en_b, valid_b, last_b;
    logic [5:0]  addr_b;
    logic [31:0] rdata_b, data_b;
    logic [2:0]  row_b, col_b;

    result_drain_ctrl #(.N(2), .DATA_W(32), .IDX_W(1), .ADDR_W(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(rdata_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
        .out_row(row_a), .out_col(col_a), .out_last(last_a)
    );

    result_drain_ctrl #(.N(8), .DATA_W(32), .IDX_W(3), .ADDR_W(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rdata_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
        .out_row(row_b), .out_col(col_b), .out_last(last_b)
    );

    initial begin
        mem_a[0] = 32'h11;
        mem_a[1] = 32'h22;
        mem_a[2] = 32'h33;
        mem_a[3] = 32'h44;
    end

    always @(posedge clk) if (rd_en_a) rdata_a <= mem_a[addr_a];
    always @(posedge clk) if (rd_en_b) rdata_b <= {26'b0, addr_b} ^ 32'hA5A5A5A5;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int cnt  = 0;
    int base = 0;
    always @(posedge clk) cnt <= cnt + 1;

    hs_t  hs_a[$];
    hs_t  hs_b[$];
    int   done_qa[$];
    int   done_cnt_b = 0;
    logic busy_log [256];
    logic rden_log [256];

    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [31:0] pdata_a, pdata_b;
    logic [2:0]  prow_b, pcol_b;
    logic        prow_a, pcol_a, plast_a, plast_b;

    always @(negedge clk) begin
        int  rel;
        hs_t h;
        rel = cnt - base;
        if (valid_a && ready_a) begin
            h.cyc = rel; h.data = data_a; h.row = {2'b0, row_a}; h.col = {2'b0, col_a}; h.last = last_a;
            hs_a.push_back(h);
        end
        if (done_a) done_qa.push_back(rel);
        if (rel >= 0 && rel < 256) begin
            busy_log[rel] = busy_a;
            rden_log[rel] = rd_en_a;
        end
        if (stall_a && !rst) begin
            chk("a_stall_valid", {63'b0, valid_a}, 64'd1);
            chk("a_stall_data", {32'b0, data_a}, {32'b0, pdata_a});
            chk("a_stall_rc", {62'b0, row_a, col_a}, {62'b0, prow_a, pcol_a});
            chk("a_stall_last", {63'b0, last_a}, {63'b0, plast_a});
        end
        stall_a = valid_a && !ready_a;
        pdata_a = data_a; prow_a = row_a; pcol_a = col_a; plast_a = last_a;
    end

    always @(negedge clk) begin
        hs_t h;
        if (valid_b && ready_b) begin
            h.cyc = cnt; h.data = data_b; h.row = row_b; h.col = col_b; h.last = last_b;
            hs_b.push_back(h);
        end
        if (done_b) done_cnt_b++;
        if (stall_b && !rst) begin
            chk("b_stall_valid", {63'b0, valid_b}, 64'd1);
            chk("b_stall_data", {32'b0, data_b}, {32'b0, pdata_b});
            chk("b_stall_rc", {58'b0, row_b, col_b}, {58'b0, prow_b, pcol_b});
            chk("b_stall_last", {63'b0, last_b}, {63'b0, plast_b});
        end
        stall_b = valid_b && !ready_b;
        pdata_b = data_b; prow_b = row_b; pcol_b = col_b; plast_b = last_b;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_run();
        hs_a.delete();
        done_qa.delete();
        base = cnt;
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_busy"}, {63'b0, busy_a}, 64'd0);
        chk({tag, "_done"}, {63'b0, done_a}, 64'd0);
        chk({tag, "_rden"}, {63'b0, rd_en_a}, 64'd0);
        chk({tag, "_addr"}, {62'b0, addr_a}, 64'd0);
        chk({tag, "_valid"}, {63'b0, valid_a}, 64'd0);
        chk({tag, "_data"}, {32'b0, data_a}, 64'd0);
        chk({tag, "_row"}, {63'b0, row_a}, 64'd0);
        chk({tag, "_col"}, {63'b0, col_a}, 64'd0);
        chk({tag, "_last"}, {63'b0, last_a}, 64'd0);
    endtask

    // Expected N=2 drain: 0x11..0x44 row-major, handshakes every 3 cycles.
    task automatic verify_a(input string tag, input int last_cyc, input int done_cyc);
        logic [31:0] exp_data [4];
        int          exp_cyc;
        exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33; exp_data[3] = 32'h44;
        chk({tag, "_hs_count"}, 64'(hs_a.size()), 64'd4);
        for (int i = 0; i < 4 && i < hs_a.size(); i++) begin
            exp_cyc = (i < 3) ? 3 * (i + 1) : last_cyc;
            chk({tag, "_hs_cyc"}, 64'(hs_a[i].cyc), 64'(exp_cyc));
            chk({tag, "_hs_data"}, {32'b0, hs_a[i].data}, {32'b0, exp_data[i]});
            chk({tag, "_hs_row"}, {61'b0, hs_a[i].row}, 64'(i / 2));
            chk({tag, "_hs_col"}, {61'b0, hs_a[i].col}, 64'(i % 2));
            chk({tag, "_hs_last"}, {63'b0, hs_a[i].last}, 64'(i == 3));
        end
        chk({tag, "_done_count"}, 64'(done_qa.size()), 64'd1);
        if (done_qa.size() > 0) chk({tag, "_done_cyc"}, 64'(done_qa[0]), 64'(done_cyc));
    endtask

    initial begin
        bit finished;
        tick(2);
        @(negedge clk);
        check_reset_a("rst_a");
        chk("rst_b_valid", {63'b0, valid_b}, 64'd0);
        chk("rst_b_busy", {63'b0, busy_b}, 64'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // single start pulse, sink always ready
        begin_run();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(20);
        verify_a("basic", 12, 13);
        chk("basic_busy_c0", {63'b0, busy_log[0]}, 64'd0);
        chk("basic_busy_c1", {63'b0, busy_log[1]}, 64'd1);
        chk("basic_busy_c13", {63'b0, busy_log[13]}, 64'd1);
        chk("basic_busy_c14", {63'b0, busy_log[14]}, 64'd0);
        chk("basic_rden_c1", {63'b0, rden_log[1]}, 64'd1);
        chk("basic_rden_c2", {63'b0, rden_log[2]}, 64'd0);

        // start re-pulsed mid-drain must be ignored
        begin_run();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(4);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(3);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(12);
        verify_a("restart_ign", 12, 13);

        // reset in cycle 7 aborts the drain
        begin_run();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(6);
        rst = 1'b1;
        @(negedge clk);
        check_reset_a("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(15);
        chk("abort_no_done", 64'(done_qa.size()), 64'd0);
        begin_run();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(20);
        verify_a("after_abort", 12, 13);

        // sink stalls 20 cycles on the last element
        begin_run();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(11);
        ready_a = 1'b0;
        tick(20);
        ready_a = 1'b1;
        tick(5);
        verify_a("last_stall", 32, 33);
        chk("last_stall_busy_c31", {63'b0, busy_log[31]}, 64'd1);

        // start tied high: back-to-back drains with one IDLE cycle between
        begin_run();
        start_a = 1'b1;
        tick(20);
        start_a = 1'b0;
        tick(20);
        chk("b2b_hs_count", 64'(hs_a.size()), 64'd8);
        chk("b2b_done_count", 64'(done_qa.size()), 64'd2);
        if (done_qa.size() > 1) begin
            chk("b2b_done0", 64'(done_qa[0]), 64'd13);
            chk("b2b_done1", 64'(done_qa[1]), 64'd27);
        end
        chk("b2b_idle_c14", {63'b0, busy_log[14]}, 64'd0);
        chk("b2b_rd_c15", {63'b0, rden_log[15]}, 64'd1);

        // N=8 drain with random sink throttling
        hs_b.delete();
        done_cnt_b = 0;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            ready_b = 1'($urandom_range(0, 1));
            tick(1);
            if (done_cnt_b > 0) finished = 1'b1;
        end
        ready_b = 1'b1;
        if (!finished) chk("b_timeout", 64'd0, 64'd1);
        tick(5);
        chk("b_hs_count", 64'(hs_b.size()), 64'd64);
        for (int i = 0; i < 64 && i < hs_b.size(); i++) begin
            chk("b_data", {32'b0, hs_b[i].data}, {32'b0, 32'(i) ^ 32'hA5A5A5A5});
            chk("b_row", {61'b0, hs_b[i].row}, 64'(i / 8));
            chk("b_col", {61'b0, hs_b[i].col}, 64'(i % 8));
            chk("b_last", {63'b0, hs_b[i].last}, 64'(i == 63));
        end
        chk("b_done_count", 64'(done_cnt_b), 64'd1);
        chk("b_idle_busy", {63'b0, busy_b}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
